time_date_counter: RTL and testbench

Timekeeping datapath of the clock: consumes the enable, count/adjust mode, item select and single-cycle up/down pulses produced by the control unit. Holds seconds, minutes, hours, day, month and year, counting once per second with a full Gregorian calendar, or stepping the selected field up or down while in adjust mode. Outputs are binary values for the display/BCD stage, plus a 1 Hz strobe for blink timing.

---
 rtl/time_date_counter.sv | 143 ++++++++++++++
 tb/tb_time_date_counter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/time_date_counter.sv
// Timekeeping datapath: seconds prescaler, one-edge Gregorian carry cascade,
// and per-field up/down adjust with in-field wrap and day clamping.
module time_date_counter #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int YEAR_INIT = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_1,
  input  logic        dem_chinh,
  input  logic [2:0]  select_item,
  input  logic        up,
  input  logic        down,
  output logic [5:0]  sec,
  output logic [5:0]  min,
  output logic [4:0]  hour,
  output logic [4:0]  day,
  output logic [3:0]  month,
  output logic [13:0] year,
  output logic        tick_1hz
);

  localparam int unsigned PRE_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(CLK_FREQ - 1);

  localparam logic [2:0] SEL_SEC   = 3'd0;
  localparam logic [2:0] SEL_MIN   = 3'd1;
  localparam logic [2:0] SEL_HOUR  = 3'd2;
  localparam logic [2:0] SEL_DAY   = 3'd3;
  localparam logic [2:0] SEL_MONTH = 3'd4;
  localparam logic [2:0] SEL_YEAR  = 3'd5;

  function automatic logic is_leap(input logic [13:0] y);
    return ((y[1:0] == 2'b00) && ((y % 14'd100) != 14'd0)) ||
           ((y % 14'd400) == 14'd0);
  endfunction

  function automatic logic [4:0] days_in_month(input logic [3:0] m,
                                               input logic [13:0] y);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
      4'd2:                    return is_leap(y) ? 5'd29 : 5'd28;
      default:                 return 5'd31;
    endcase
  endfunction

  // Step a value one place within [lo, hi], wrapping at both ends.
  function automatic logic [13:0] step_wrap(input logic [13:0] v,
                                            input logic [13:0] lo,
                                            input logic [13:0] hi,
                                            input logic        inc);
    if (inc) return (v >= hi) ? lo : v + 14'd1;
    else     return (v <= lo) ? hi : v - 14'd1;
  endfunction

  logic [PRE_W-1:0] pre;
  logic             count_active;
  logic             adj_step;
  logic [4:0]       dim_cur;

  logic [5:0]  sec_nxt;
  logic [5:0]  min_nxt;
  logic [4:0]  hour_nxt;
  logic [4:0]  day_nxt;
  logic [3:0]  month_nxt;
  logic [13:0] year_nxt;

  assign count_active = en_1 & ~dem_chinh;
  assign tick_1hz     = count_active && (pre == PRE_TC);
  assign adj_step     = dem_chinh & (up ^ down);
  assign dim_cur      = days_in_month(month, year);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                pre <= '0;
    else if (!count_active) pre <= '0;
    else if (pre == PRE_TC) pre <= '0;
    else                    pre <= pre + PRE_W'(1);
  end

  always_comb begin
    sec_nxt   = sec;
    min_nxt   = min;
    hour_nxt  = hour;
    day_nxt   = day;
    month_nxt = month;
    year_nxt  = year;
    if (tick_1hz) begin
      // Full cascade resolves in one edge; each field only moves when all lower ones wrap.
      sec_nxt = 6'(step_wrap({8'd0, sec}, 14'd0, 14'd59, 1'b1));
      if (sec == 6'd59) begin
        min_nxt = 6'(step_wrap({8'd0, min}, 14'd0, 14'd59, 1'b1));
        if (min == 6'd59) begin
          hour_nxt = 5'(step_wrap({9'd0, hour}, 14'd0, 14'd23, 1'b1));
          if (hour == 5'd23) begin
            day_nxt = 5'(step_wrap({9'd0, day}, 14'd1, {9'd0, dim_cur}, 1'b1));
            if (day >= dim_cur) begin
              month_nxt = 4'(step_wrap({10'd0, month}, 14'd1, 14'd12, 1'b1));
              if (month == 4'd12)
                year_nxt = step_wrap(year, 14'd0, 14'd9999, 1'b1);
            end
          end
        end
      end
    end else if (adj_step) begin
      case (select_item)
        SEL_SEC:  sec_nxt  = 6'(step_wrap({8'd0, sec}, 14'd0, 14'd59, up));
        SEL_MIN:  min_nxt  = 6'(step_wrap({8'd0, min}, 14'd0, 14'd59, up));
        SEL_HOUR: hour_nxt = 5'(step_wrap({9'd0, hour}, 14'd0, 14'd23, up));
        SEL_DAY:  day_nxt  = 5'(step_wrap({9'd0, day}, 14'd1, {9'd0, dim_cur}, up));
        SEL_MONTH: begin
          month_nxt = 4'(step_wrap({10'd0, month}, 14'd1, 14'd12, up));
          if (day > days_in_month(month_nxt, year))
            day_nxt = days_in_month(month_nxt, year);
        end
        SEL_YEAR: begin
          year_nxt = step_wrap(year, 14'd0, 14'd9999, up);
          if (day > days_in_month(month, year_nxt))
            day_nxt = days_in_month(month, year_nxt);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec   <= 6'd0;
      min   <= 6'd0;
      hour  <= 5'd0;
      day   <= 5'd1;
      month <= 4'd1;
      year  <= 14'(YEAR_INIT);
    end else begin
      sec   <= sec_nxt;
      min   <= min_nxt;
      hour  <= hour_nxt;
      day   <= day_nxt;
      month <= month_nxt;
      year  <= year_nxt;
    end
  end

endmodule

// File: tb/tb_time_date_counter.sv
// Directed bench for time_date_counter with a 4-cycle second: calendar
// cascade vectors, adjust wraps, day clamping, no-change cases and reset.
module tb_time_date_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_1 = 1'b0;
  logic        dem_chinh = 1'b0;
  logic [2:0]  select_item = 3'd0;
  logic        up = 1'b0;
  logic        down = 1'b0;
  logic [5:0]  sec;
  logic [5:0]  min;
  logic [4:0]  hour;
  logic [4:0]  day;
  logic [3:0]  month;
  logic [13:0] year;
  logic        tick_1hz;

  int n_checks = 0;
  int n_fail   = 0;

  time_date_counter #(.CLK_FREQ(4), .YEAR_INIT(2000)) dut (
    .clk(clk), .rst(rst), .en_1(en_1), .dem_chinh(dem_chinh),
    .select_item(select_item), .up(up), .down(down),
    .sec(sec), .min(min), .hour(hour), .day(day), .month(month),
    .year(year), .tick_1hz(tick_1hz)
  );

  always #5 clk = ~clk;

  typedef struct {
    int y, mo, d, h, mi, s;
    int ey, emo, ed, eh, emi, es;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_dt(input string tag, input int y, input int mo, input int d,
                          input int h, input int mi, input int s);
    check({tag, " year"},  int'(year),  y);
    check({tag, " month"}, int'(month), mo);
    check({tag, " day"},   int'(day),   d);
    check({tag, " hour"},  int'(hour),  h);
    check({tag, " min"},   int'(min),   mi);
    check({tag, " sec"},   int'(sec),   s);
  endtask

  task automatic do_reset();
    rst = 1'b1; en_1 = 1'b0; dem_chinh = 1'b0; up = 1'b0; down = 1'b0;
    select_item = 3'd0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Hold up (or down) for n consecutive cycles on one field.
  task automatic hold_step(input logic [2:0] s, input logic u, input int n);
    if (n > 0) begin
      dem_chinh = 1'b1; select_item = s; up = u; down = ~u;
      repeat (n) @(negedge clk);
      up = 1'b0; down = 1'b0;
    end
  endtask

  task automatic set_dt(input int y, input int mo, input int d,
                        input int h, input int mi, input int s);
    int u;
    do_reset();
    u = (y - 2000 + 10000) % 10000;
    if (u <= 5000) hold_step(3'd5, 1'b1, u);
    else           hold_step(3'd5, 1'b0, 10000 - u);
    hold_step(3'd4, 1'b1, mo - 1);
    hold_step(3'd3, 1'b1, d - 1);
    hold_step(3'd2, 1'b1, h);
    hold_step(3'd1, 1'b1, mi);
    hold_step(3'd0, 1'b1, s);
  endtask

  task automatic run_one_tick(input string tag);
    int n;
    n = 0;
    dem_chinh = 1'b0; en_1 = 1'b1;
    @(negedge clk);
    while (!tick_1hz && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, " tick seen"}, int'(tick_1hz), 1);
    @(negedge clk);
    en_1 = 1'b0;
  endtask

  initial begin
    vecs[0] = '{2023, 12, 31, 23, 59, 59, 2024, 1, 1, 0, 0, 0};
    vecs[1] = '{9999, 12, 31, 23, 59, 59,    0, 1, 1, 0, 0, 0};
    vecs[2] = '{2024,  2, 28, 23, 59, 59, 2024, 2, 29, 0, 0, 0};
    vecs[3] = '{2024,  2, 29, 23, 59, 59, 2024, 3, 1, 0, 0, 0};
    vecs[4] = '{2100,  2, 28, 23, 59, 59, 2100, 3, 1, 0, 0, 0};
    vecs[5] = '{2000,  2, 28, 23, 59, 59, 2000, 2, 29, 0, 0, 0};
    vecs[6] = '{2000,  1,  1, 12, 34, 56, 2000, 1, 1, 12, 34, 57};

    repeat (2) @(negedge clk);
    check_dt("reset", 2000, 1, 1, 0, 0, 0);
    check("reset tick", int'(tick_1hz), 0);

    // Basic counting: tick on every 4th active edge, sec follows.
    rst = 1'b0; en_1 = 1'b1; dem_chinh = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      check($sformatf("count%0d tick", i), int'(tick_1hz), (i % 4 == 3) ? 1 : 0);
      check($sformatf("count%0d sec", i), int'(sec), i / 4);
    end
    check("count min", int'(min), 0);

    for (int i = 0; i < 7; i++) begin
      set_dt(vecs[i].y, vecs[i].mo, vecs[i].d, vecs[i].h, vecs[i].mi, vecs[i].s);
      check_dt($sformatf("v%0d set", i), vecs[i].y, vecs[i].mo, vecs[i].d,
               vecs[i].h, vecs[i].mi, vecs[i].s);
      run_one_tick($sformatf("v%0d", i));
      check_dt($sformatf("v%0d tick", i), vecs[i].ey, vecs[i].emo, vecs[i].ed,
               vecs[i].eh, vecs[i].emi, vecs[i].es);
    end

    // Adjust wraps stay inside their field.
    do_reset();
    hold_step(3'd0, 1'b0, 1);
    check("sec wrap down", int'(sec), 59);
    check("sec wrap min", int'(min), 0);

    do_reset();
    hold_step(3'd2, 1'b1, 23);
    check("hour set 23", int'(hour), 23);
    hold_step(3'd2, 1'b1, 1);
    check("hour wrap up", int'(hour), 0);
    check("hour wrap day", int'(day), 1);

    do_reset();
    hold_step(3'd3, 1'b1, 30);
    check("day set 31", int'(day), 31);
    hold_step(3'd3, 1'b1, 1);
    check("day wrap up", int'(day), 1);
    check("day wrap month", int'(month), 1);

    // Clamp after month and year adjust.
    set_dt(2024, 1, 31, 0, 0, 0);
    hold_step(3'd4, 1'b1, 1);
    check_dt("clamp month", 2024, 2, 29, 0, 0, 0);
    hold_step(3'd5, 1'b1, 1);
    check_dt("clamp year", 2025, 2, 28, 0, 0, 0);

    // No-change cases.
    dem_chinh = 1'b1; select_item = 3'd0; up = 1'b1; down = 1'b1;
    @(negedge clk);
    up = 1'b0; down = 1'b0;
    check("up+down sec", int'(sec), 0);
    select_item = 3'd6; up = 1'b1;
    @(negedge clk);
    select_item = 3'd7; up = 1'b0; down = 1'b1;
    @(negedge clk);
    down = 1'b0;
    check_dt("sel none", 2025, 2, 28, 0, 0, 0);
    dem_chinh = 1'b0; en_1 = 1'b0; select_item = 3'd0; up = 1'b1;
    @(negedge clk);
    up = 1'b0; down = 1'b1;
    @(negedge clk);
    down = 1'b0;
    check("count-mode up sec", int'(sec), 0);

    // Freeze with dem_chinh=1: prescaler must restart from 0.
    en_1 = 1'b1; dem_chinh = 1'b0;
    repeat (2) @(negedge clk);
    dem_chinh = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 19) check("adjust freeze tick", int'(tick_1hz), 0);
    end
    check_dt("adjust freeze", 2025, 2, 28, 0, 0, 0);
    dem_chinh = 1'b0;
    repeat (2) @(negedge clk);
    check("resume adj edge2 tick", int'(tick_1hz), 0);
    @(negedge clk);
    check("resume adj edge3 tick", int'(tick_1hz), 1);
    @(negedge clk);
    check("resume adj sec", int'(sec), 1);

    // Freeze with en_1=0.
    repeat (2) @(negedge clk);
    en_1 = 1'b0;
    repeat (20) @(negedge clk);
    check("enable freeze tick", int'(tick_1hz), 0);
    check("enable freeze sec", int'(sec), 1);
    en_1 = 1'b1;
    repeat (2) @(negedge clk);
    check("resume en edge2 tick", int'(tick_1hz), 0);
    @(negedge clk);
    check("resume en edge3 tick", int'(tick_1hz), 1);
    @(negedge clk);
    check("resume en sec", int'(sec), 2);

    // Reset asserted across the cascade edge.
    set_dt(2023, 12, 31, 23, 59, 59);
    dem_chinh = 1'b0; en_1 = 1'b1;
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!tick_1hz && n < 10) begin
        @(negedge clk);
        n++;
      end
      check("midrst tick seen", int'(tick_1hz), 1);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_dt("midrst", 2000, 1, 1, 0, 0, 0);
    check("midrst tick", int'(tick_1hz), 0);
    repeat (3) @(negedge clk);
    check("midrst edge3 sec", int'(sec), 0);
    @(negedge clk);
    check("midrst edge4 sec", int'(sec), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
